// File: rtl/conv_window_buffer.sv
// Streaming KxK window generator: K-1 line buffers feed a KxK shift-register window, stride 1, no padding.
// Optional CONV_WIN_COORD_EN adds out_row/out_col (top-left coordinate of the emitted window).
module conv_window_buffer #(
  parameter int DATA_WIDTH  = 16,
  parameter int KERNEL_SIZE = 3,
  parameter int IMG_WIDTH   = 28,
  parameter int IMG_HEIGHT  = 28,
  localparam int ROW_W = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1,
  localparam int COL_W = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic signed [DATA_WIDTH-1:0] in_pixel,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic signed [DATA_WIDTH-1:0] window [KERNEL_SIZE*KERNEL_SIZE],
  output logic                         out_last
`ifdef CONV_WIN_COORD_EN
  ,
  output logic [ROW_W-1:0]             out_row,
  output logic [COL_W-1:0]             out_col
`endif
);

  localparam int K = KERNEL_SIZE;
  localparam int N = K * K;

  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_KM1  = ROW_W'(K - 1);
  localparam logic [COL_W-1:0] COL_KM1  = COL_W'(K - 1);

  logic [ROW_W-1:0] row;
  logic [COL_W-1:0] col;

  // linebuf[0] holds the previous row, linebuf[K-2] the oldest row still needed.
  logic signed [DATA_WIDTH-1:0] linebuf [K-1][IMG_WIDTH];
  logic signed [DATA_WIDTH-1:0] new_col [K];

  logic accept;
  logic win_done;
  logic frame_end;

  // The window register only advances when it is empty or being consumed.
  assign in_ready  = !out_valid || out_ready;
  assign accept    = in_valid && in_ready;
  assign win_done  = (row >= ROW_KM1) && (col >= COL_KM1);
  assign frame_end = (row == ROW_LAST) && (col == COL_LAST);

  // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    for (int i = 0; i < K; i++) new_col[i] = in_pixel;
    for (int i = 0; i < K - 1; i++) new_col[i] = linebuf[K-2-i][col];
  end

  // NOTE: line-buffer storage has no reset; rows < K-1 overwrite it before it can reach a window.
  always_ff @(posedge clk) begin
    if (accept) begin
      linebuf[0][col] <= in_pixel;
      for (int k = 1; k < K - 1; k++) linebuf[k][col] <= linebuf[k-1][col];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      row <= '0;
      col <= '0;
    end else if (accept) begin
      if (col == COL_LAST) begin
        col <= '0;
        row <= (row == ROW_LAST) ? '0 : row + ROW_W'(1);
      end else begin
        col <= col + COL_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < N; k++) window[k] <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else if (accept) begin
      for (int i = 0; i < K; i++) begin
        for (int j = 0; j < K - 1; j++) window[K*i+j] <= window[K*i+j+1];
        window[K*i+K-1] <= new_col[i];
      end
      out_valid <= win_done;
      out_last  <= win_done && frame_end;
    end else if (out_ready) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end
  end

`ifdef CONV_WIN_COORD_EN
  // Coordinates track the window register: updated only when a new window is loaded.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_row <= '0;
      out_col <= '0;
    end else if (accept && win_done) begin
      out_row <= row - ROW_KM1;
      out_col <= col - COL_KM1;
    end
  end
`endif

endmodule

// File: tb/tb_conv_window_buffer.sv
// Scoreboard bench for conv_window_buffer (W=4, H=4, K=3): driver pushes expected windows, monitor pops on handshake.
module tb_conv_window_buffer;
  localparam int DW = 16;
  localparam int K  = 3;
  localparam int W  = 4;
  localparam int H  = 4;
  localparam int N  = K * K;

  typedef struct packed {
    logic [N*DW-1:0] pix;
    logic            last;
    logic [7:0]      row;
    logic [7:0]      col;
  } exp_t;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 in_valid;
  logic                 in_ready;
  logic signed [DW-1:0] in_pixel;
  logic                 out_valid;
  logic                 out_ready;
  logic signed [DW-1:0] window [N];
  logic                 out_last;
`ifdef CONV_WIN_COORD_EN
  logic [1:0]           out_row;
  logic [1:0]           out_col;
`endif

  exp_t q[$];
  int   n_cmp = 0;
  int   n_fail = 0;
  int   n_win = 0;
  int   exp_win = 0;
  int   n_last = 0;
  int   exp_last = 0;

  always #5 clk = ~clk;

  conv_window_buffer #(
    .DATA_WIDTH (DW),
    .KERNEL_SIZE(K),
    .IMG_WIDTH  (W),
    .IMG_HEIGHT (H)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_pixel (in_pixel),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .window   (window),
    .out_last (out_last)
`ifdef CONV_WIN_COORD_EN
    ,
    .out_row  (out_row),
    .out_col  (out_col)
`endif
  );

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [N*DW-1:0] win_vec();
    logic [N*DW-1:0] v;
    for (int k = 0; k < N; k++) v[k*DW +: DW] = window[k];
    return v;
  endfunction

  function automatic logic [N*DW-1:0] list_vec(input int vals [N]);
    logic [N*DW-1:0] v;
    for (int k = 0; k < N; k++) v[k*DW +: DW] = DW'(vals[k]);
    return v;
  endfunction

  task automatic push_hand(input int vals [N], input bit last, input int r, input int c);
    exp_t e;
    e.pix  = list_vec(vals);
    e.last = last;
    e.row  = 8'(r);
    e.col  = 8'(c);
    q.push_back(e);
    exp_win++;
    if (last) exp_last++;
  endtask

  // Small model: window entry (i,j) at top-left (r0,c0) is raster pixel base + (r0+i)*W + c0+j.
  task automatic push_frame(input int base);
    int vals [N];
    for (int r0 = 0; r0 <= H - K; r0++)
      for (int c0 = 0; c0 <= W - K; c0++) begin
        for (int i = 0; i < K; i++)
          for (int j = 0; j < K; j++) vals[K*i+j] = base + (r0 + i) * W + c0 + j;
        push_hand(vals, (r0 == H - K) && (c0 == W - K), r0, c0);
      end
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int v);
    bit done;
    int guard;
    done     = 1'b0;
    guard    = 0;
    in_pixel = DW'(v);
    in_valid = 1'b1;
    while (!done) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        #1;
        done = 1'b1;
      end else if (guard++ > 50) begin
        check("in_ready timeout", 1'b0, 1'b1);
        done = 1'b1;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic stream(input int base, input bit bubbles);
    for (int i = 0; i < W * H; i++) begin
      if (bubbles) repeat ($urandom_range(0, 1)) idle();
      send(base + i);
    end
  endtask

  task automatic drain(input string name);
    int g;
    g = 0;
    while (q.size() != 0 && g < 30) begin
      idle();
      g++;
    end
    check(name, q.size(), 0);
    repeat (3) idle();
  endtask

  task automatic check_reset_state(input string name);
    @(negedge clk);
    check({name, " out_valid"}, out_valid, 1'b0);
    check({name, " out_last"}, out_last, 1'b0);
    check({name, " window"}, win_vec(), '0);
    check({name, " in_ready"}, in_ready, 1'b1);
  endtask

  // Monitor: every handshake must match the head of the expected queue.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && out_valid && out_ready) begin
        n_win++;
        if (out_last) n_last++;
        if (q.size() == 0) begin
          check("unexpected window", win_vec(), '0);
        end else begin
          e = q.pop_front();
          check("window", win_vec(), e.pix);
          check("out_last", out_last, e.last);
`ifdef CONV_WIN_COORD_EN
          check("out_row", out_row, e.row[1:0]);
          check("out_col", out_col, e.col[1:0]);
`endif
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0 [N] = '{0, 1, 2, 4, 5, 6, 8, 9, 10};
    int w1 [N] = '{1, 2, 3, 5, 6, 7, 9, 10, 11};
    int w2 [N] = '{4, 5, 6, 8, 9, 10, 12, 13, 14};
    int w3 [N] = '{5, 6, 7, 9, 10, 11, 13, 14, 15};

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_pixel  = '0;
    out_ready = 1'b1;
    repeat (2) idle();
    check_reset_state("reset");
    idle();
    rst = 1'b0;

    // Continuous stream with hand-listed windows.
    push_hand(w0, 1'b0, 0, 0);
    push_hand(w1, 1'b0, 0, 1);
    push_hand(w2, 1'b0, 1, 0);
    push_hand(w3, 1'b1, 1, 1);
    stream(0, 1'b0);
    drain("t1 drain");

    // Input bubbles.
    push_frame(0);
    stream(0, 1'b1);
    drain("t2 drain");

    // Output stall while the first window is presented.
    push_frame(0);
    out_ready = 1'b0;
    for (int i = 0; i <= 10; i++) send(i);
    in_pixel = DW'(11);
    in_valid = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("stall in_ready", in_ready, 1'b0);
      check("stall out_valid", out_valid, 1'b1);
      check("stall window", win_vec(), list_vec(w0));
      idle();
    end
    out_ready = 1'b1;
    for (int i = 11; i < W * H; i++) send(i);
    drain("t3 drain");

    // Two back-to-back frames.
    push_frame(0);
    push_frame(100);
    stream(0, 1'b0);
    stream(100, 1'b0);
    drain("t4 drain");

    // Abandoned frame with distinct values, reset mid-frame, then a clean frame.
    for (int i = 0; i < 10; i++) send(200 + i);
    rst = 1'b1;
    idle();
    check_reset_state("mid reset");
    idle();
    rst = 1'b0;
    push_frame(0);
    stream(0, 1'b0);
    drain("t5 drain");

    check("window count", n_win, exp_win);
    check("out_last count", n_last, exp_last);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
